mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one combinational 4x4 unsigned multiplier (8-bit product) among NREQ requesters.
//  Each requester presents operands with a valid/ready handshake.
//  A round-robin arbiter grants one request per cycle.
//  The product and the winner's index are registered into a single output slot with its own valid/ready handshake.
//  Sits between client blocks and the shared multiplier datapath; gives full throughput (one product per clock).
// PARAMETERS
//  NREQ  4  number of requesters, 2..8
//  IDW   2  width of rsp_id; must equal clog2(NREQ) (min 1)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  req_valid  in   NREQ     per-requester operand valid
//  req_ready  out  NREQ     per-requester accept; at most one bit high per cycle
//  req_a      in   4*NREQ   operand A, requester i at [4i+3:4i]
//  req_b      in   4*NREQ   operand B, requester i at [4i+3:4i]
//  rsp_valid  out  1        product slot holds a result
//  rsp_ready  in   1        downstream accepts the result
//  rsp_p      out  8        unsigned product A*B, range 0..225
//  rsp_id     out  IDW      index of the requester that produced rsp_p
// BEHAVIOUR
//  Reset values: rsp_valid=0, rsp_p=0, rsp_id=0, rr_ptr=0.
//  - rst_n low forces these values immediately, mid-transaction included.
//  - A result pending at reset is discarded.
//  Slot state (2-state FSM):
//  - EMPTY (rsp_valid=0) <-> FULL (rsp_valid=1).
//  - slot_free = ~rsp_valid | rsp_ready.
//  Arbitration (combinational):
//  - Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
//  - The first i with req_valid[i]=1 wins.
//  - req_ready[i] = win[i] & slot_free. It may depend combinationally on req_valid and rsp_ready.
//  Accept = |(req_valid & req_ready). On an accepting edge:
//  - rsp_p  <= a_win * b_win, computed at full 8-bit width with no truncation.
//  - rsp_id <= winner index; rsp_valid <= 1.
//  - rr_ptr <= (winner+1) mod NREQ.
//  Latency is 1 clock: a request accepted at edge N is visible on rsp_* after edge N.
//  Drain with no accept (rsp_valid & rsp_ready, no winner): rsp_valid <= 0. rsp_p and rsp_id keep their old values.
//  Simultaneous drain and accept: the slot is overwritten with the new result and rsp_valid stays 1 (back-to-back, no bubble).
//  Backpressure (rsp_valid=1, rsp_ready=0):
//  - All req_ready are 0.
//  - rsp_p and rsp_id are held stable.
//  - rr_ptr is frozen.
//  No request (req_valid=0): rr_ptr is unchanged.
//  Requester-side rules:
//  - A requester may drop req_valid before it is accepted; nothing is recorded.
//  - The block makes no assumption about the stability of the operands.
//  - Only operands present on the accepting edge are used.
//  Fairness: a continuously-valid requester waits at most NREQ-1 accepts.
//  Wrap-around: rr_ptr=NREQ-1 advances to 0.
// STRUCTURE
//  Shared header mult_defs.vh holds:
//  - MULT_OPW=4 and MULT_PW=8.
//  - the NREQ limit check and the IDW computation macro.
//  Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs a one-hot grant and the grant index.
//  Multiplier: the team's 4x4 array multiplier, instantiated once on the muxed winner operands.
//  Top level holds the operand mux, the slot register, rr_ptr and the ready logic.
// TESTING
//  1. Reset mid-FULL (rsp_valid=1, rsp_p=0x2A): assert rst_n=0 -> rsp_valid, rsp_p and rsp_id read 0 in the same cycle.
//  2. Single request: req0 A=15, B=15 with rsp_ready=1 -> next cycle rsp_p=225 (0xE1), rsp_id=0. A=0, B=9 -> 0.
//  3. All four valid every cycle, rsp_ready=1 -> grant order 0,1,2,3,0,... with one product per clock and no bubbles.
//  4. Backpressure: rsp_ready=0 for 5 cycles while FULL (3*7=21)
//     -> all req_ready=0, and rsp_p=21 and rsp_id are stable.
//     -> on release, the next result follows back-to-back.
//  5. Simultaneous drain and accept:
//     - Setup: slot holds 6*6=36; req2 is valid with 9*4; rsp_ready=1.
//     - Expect: next cycle rsp_p=36, rsp_id=2, rsp_valid stays 1; rr_ptr=3.
//  6. Wrap and idle: rr_ptr=3 with only req1 valid -> req1 wins and rr_ptr=2.
//     Then 3 idle cycles -> rr_ptr unchanged and rsp_valid drops after the drain.
//  All results are checked against a scoreboard (A*B, id) for every accepted request.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants, slot state type and the 4x4 array multiplier used by mult_share_arbiter.
// Also holds the parameter helpers used to validate NREQ/IDW at elaboration.
package mult_share_arbiter_pkg;

    localparam int MULT_OPW = 4;
    localparam int MULT_PW  = 8;
    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Index width for n requesters, never below one bit.
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Shift-and-add array multiplier: one partial-product row per bit of b.
    function automatic logic [MULT_PW-1:0] mult_array_4x4(
        input logic [MULT_OPW-1:0] a,
        input logic [MULT_OPW-1:0] b
    );
        logic [MULT_PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < MULT_OPW; i++) begin
            if (b[i]) begin
                acc = acc + ({{(MULT_PW-MULT_OPW){1'b0}}, a} << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after ptr (wrapping) wins.
// Produces a one-hot grant, the winner index and a request-present flag.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set request is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// One 4x4 multiplier shared by NREQ requesters through a round-robin arbiter,
// feeding a single registered result slot. Full throughput: one product per clock.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [MULT_OPW*NREQ-1:0] req_a,
    input  logic [MULT_OPW*NREQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [MULT_PW-1:0]       rsp_p,
    output logic [IDW-1:0]           rsp_id,
    output slot_state_e              dbg_state,
    output logic [IDW-1:0]           dbg_rr_ptr
);

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX || IDW != idw_of(NREQ)) begin : g_bad_params
        $error("mult_share_arbiter: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready only rises for the arbitration winner and only while the slot can take a result.
    slot_state_e         state, state_next;
    logic [IDW-1:0]      rr_ptr, rr_ptr_next;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      win_idx;
    logic                win_any;
    logic                slot_free;
    logic                accept;
    logic [MULT_OPW-1:0] a_win, b_win;
    logic [MULT_PW-1:0]  product;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign rsp_valid  = (state == SLOT_FULL);
    assign slot_free  = ~rsp_valid | rsp_ready;
    assign req_ready  = grant & {NREQ{slot_free}};
    assign accept     = win_any & slot_free;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

    // Grant is one-hot, so an OR of masked operand fields selects the winner.
    always_comb begin
        a_win = '0;
        b_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_win = a_win | req_a[i*MULT_OPW +: MULT_OPW];
                b_win = b_win | req_b[i*MULT_OPW +: MULT_OPW];
            end
        end
    end

    assign product = mult_array_4x4(a_win, b_win);

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        case (state)
            SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
            SLOT_FULL: begin
                if (accept)         state_next = SLOT_FULL;
                else if (rsp_ready) state_next = SLOT_EMPTY;
            end
            default: state_next = SLOT_EMPTY;
        endcase
        if (accept) begin
            rr_ptr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SLOT_EMPTY;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // Payload only moves on accept; a plain drain leaves the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_p  <= '0;
            rsp_id <= '0;
        end else if (accept) begin
            rsp_p  <= product;
            rsp_id <= win_idx;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed, table-driven bench for mult_share_arbiter with a result scoreboard.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [15:0]     req_a;
    logic [15:0]     req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_p;
    logic [1:0]      rsp_id;
    logic            dbg_state;
    logic [1:0]      dbg_rr_ptr;

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] a;
        logic [15:0] b;
        logic        rr;
        logic [3:0]  ready;
        logic        vld;
        logic [7:0]  p;
        logic [1:0]  id;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vecs[25];
    logic [9:0] exp_q[$];
    int n_checks;
    int n_fail;

    mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_p      (rsp_p),
        .rsp_id     (rsp_id),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic [15:0] a, input logic [15:0] b,
                                input logic rr, input logic [3:0] ready, input logic vld,
                                input int p, input int id, input int ptr);
        vec_t v;
        v.rv = rv; v.a = a; v.b = b; v.rr = rr; v.ready = ready; v.vld = vld;
        v.p = 8'(p); v.id = 2'(id); v.ptr = 2'(ptr);
        return v;
    endfunction

    // Driver: apply one vector, check ready before the edge, registered outputs after it.
    task automatic apply(input int n);
        logic [3:0] hs;
        logic [9:0] exp_e;
        bit         pushed;
        int         av, bv;
        pushed    = 0;
        req_valid = vecs[n].rv;
        req_a     = vecs[n].a;
        req_b     = vecs[n].b;
        rsp_ready = vecs[n].rr;
        #3;
        check($sformatf("v%0d req_ready", n), int'(req_ready), int'(vecs[n].ready));
        hs = req_valid & req_ready;
        check($sformatf("v%0d ready_onehot", n), int'($countones(hs) <= 1), 1);
        for (int k = 0; k < NREQ; k++) begin
            if (hs[k]) begin
                av = int'((req_a >> (4*k)) & 16'hF);
                bv = int'((req_b >> (4*k)) & 16'hF);
                exp_q.push_back({2'(k), 8'(av * bv)});
                pushed = 1;
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d rsp_valid", n), int'(rsp_valid), int'(vecs[n].vld));
        check($sformatf("v%0d rsp_p", n), int'(rsp_p), int'(vecs[n].p));
        check($sformatf("v%0d rsp_id", n), int'(rsp_id), int'(vecs[n].id));
        check($sformatf("v%0d rr_ptr", n), int'(dbg_rr_ptr), int'(vecs[n].ptr));
        if (pushed) begin
            exp_e = exp_q.pop_front();
            check($sformatf("v%0d sb_p", n), int'(rsp_p), int'(exp_e[7:0]));
            check($sformatf("v%0d sb_id", n), int'(rsp_id), int'(exp_e[9:8]));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Single requests, including pointer wrap 3 -> 0
        vecs[0]  = mk(4'b0001, 16'h000F, 16'h000F, 1, 4'b0001, 1, 225, 0, 1);
        vecs[1]  = mk(4'b1000, 16'h0000, 16'h9000, 1, 4'b1000, 1,   0, 3, 0);
        // All four valid: grant order 0,1,2,3,0 with no bubbles
        vecs[2]  = mk(4'b1111, 16'h7531, 16'h8642, 1, 4'b0001, 1,   2, 0, 1);
        vecs[3]  = mk(4'b1111, 16'h7531, 16'h8642, 1, 4'b0010, 1,  12, 1, 2);
        vecs[4]  = mk(4'b1111, 16'h7531, 16'h8642, 1, 4'b0100, 1,  30, 2, 3);
        vecs[5]  = mk(4'b1111, 16'h7531, 16'h8642, 1, 4'b1000, 1,  56, 3, 0);
        vecs[6]  = mk(4'b1111, 16'h7531, 16'h8642, 1, 4'b0001, 1,   2, 0, 1);
        // Backpressure on 3*7=21 for five cycles, operands wiggling
        vecs[7]  = mk(4'b0010, 16'h0030, 16'h0070, 1, 4'b0010, 1,  21, 1, 2);
        vecs[8]  = mk(4'b1111, 16'h7531, 16'h8642, 0, 4'b0000, 1,  21, 1, 2);
        vecs[9]  = mk(4'b1111, 16'hFFFF, 16'hFFFF, 0, 4'b0000, 1,  21, 1, 2);
        vecs[10] = mk(4'b1111, 16'h1234, 16'h5678, 0, 4'b0000, 1,  21, 1, 2);
        vecs[11] = mk(4'b1111, 16'hABCD, 16'hEF01, 0, 4'b0000, 1,  21, 1, 2);
        vecs[12] = mk(4'b1111, 16'h7531, 16'h8642, 0, 4'b0000, 1,  21, 1, 2);
        vecs[13] = mk(4'b1111, 16'h7531, 16'h8642, 1, 4'b0100, 1,  30, 2, 3);
        // Simultaneous drain and accept: 6*6 in slot, req2 brings 9*4
        vecs[14] = mk(4'b0001, 16'h0006, 16'h0006, 1, 4'b0001, 1,  36, 0, 1);
        vecs[15] = mk(4'b0100, 16'h0900, 16'h0400, 1, 4'b0100, 1,  36, 2, 3);
        // Wrap from ptr=3 to req1, then idle with drain
        vecs[16] = mk(4'b0010, 16'h0020, 16'h0050, 1, 4'b0010, 1,  10, 1, 2);
        vecs[17] = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0,  10, 1, 2);
        vecs[18] = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0,  10, 1, 2);
        vecs[19] = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0,  10, 1, 2);
        // Accept into an empty slot with rsp_ready=0, then a requester withdraws
        vecs[20] = mk(4'b0100, 16'h0D00, 16'h0B00, 0, 4'b0100, 1, 143, 2, 3);
        vecs[21] = mk(4'b0100, 16'h0100, 16'h0100, 0, 4'b0000, 1, 143, 2, 3);
        vecs[22] = mk(4'b0000, 16'h0000, 16'h0000, 0, 4'b0000, 1, 143, 2, 3);
        vecs[23] = mk(4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 143, 2, 3);
        // Fill slot with 0x2A for the mid-FULL reset
        vecs[24] = mk(4'b0100, 16'h0600, 16'h0700, 0, 4'b0100, 1,  42, 2, 3);

        #2;
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset rsp_p", int'(rsp_p), 0);
        check("reset rsp_id", int'(rsp_id), 0);
        check("reset rr_ptr", int'(dbg_rr_ptr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 25; n++) begin
            apply(n);
        end

        // Asynchronous reset while FULL with a pending result
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset rsp_valid", int'(rsp_valid), 0);
        check("midreset rsp_p", int'(rsp_p), 0);
        check("midreset rsp_id", int'(rsp_id), 0);
        check("midreset rr_ptr", int'(dbg_rr_ptr), 0);
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postreset rsp_valid", int'(rsp_valid), 0);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
